// File: rtl/alu_exec_stage.sv
// RV32I execute stage: operand/function select, per-function ALU, result held in a 2-entry skid buffer (M then S).
// Latency 1 cycle; in_ready depends only on registered skid state, so out_ready has no combinational path to decode.
module alu_exec_stage #(
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_funct3,
    input  logic            in_funct7b5,
    input  logic            in_use_imm,
    input  logic [31:0]     in_rs1,
    input  logic [31:0]     in_rs2,
    input  logic [31:0]     in_imm,
    input  logic [RD_W-1:0] in_rd,
    input  logic            in_we,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_result,
    output logic [RD_W-1:0] out_rd,
    output logic            out_we
);

    logic [31:0]     op_b;
    logic [4:0]      shamt;
    logic [31:0]     alu_res;
    logic            new_we;
    logic            accept;
    logic            m_load_ok;

    logic            m_valid, s_valid;
    logic [31:0]     m_result, s_result;
    logic [RD_W-1:0] m_rd, s_rd;
    logic            m_we, s_we;

    assign op_b   = in_use_imm ? in_imm : in_rs2;
    assign shamt  = op_b[4:0];
    assign new_we = in_we && (in_rd != '0);

    always_comb begin
        alu_res = '0;
        case (in_funct3)
            // ADDI carries imm[10] in funct7b5, so only the register form may subtract
            3'b000:  alu_res = (in_funct7b5 && !in_use_imm) ? in_rs1 - op_b : in_rs1 + op_b;
            3'b001:  alu_res = in_rs1 << shamt;
            3'b010:  alu_res = {31'b0, $signed(in_rs1) < $signed(op_b)};
            3'b011:  alu_res = {31'b0, in_rs1 < op_b};
            3'b100:  alu_res = in_rs1 ^ op_b;
            3'b101:  alu_res = in_funct7b5 ? 32'($signed(in_rs1) >>> shamt) : in_rs1 >> shamt;
            3'b110:  alu_res = in_rs1 | op_b;
            3'b111:  alu_res = in_rs1 & op_b;
            default: alu_res = '0;
        endcase
    end

    assign in_ready  = !s_valid;
    assign accept    = in_valid && in_ready && !flush;
    assign m_load_ok = !m_valid || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid  <= 1'b0;
            s_valid  <= 1'b0;
            m_result <= '0;
            m_rd     <= '0;
            m_we     <= 1'b0;
            s_result <= '0;
            s_rd     <= '0;
            s_we     <= 1'b0;
        end else if (flush) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
        end else if (m_load_ok) begin
            if (s_valid) begin
                // Skid entry is older than anything arriving now: promote it first
                m_valid  <= 1'b1;
                m_result <= s_result;
                m_rd     <= s_rd;
                m_we     <= s_we;
                s_valid  <= accept;
                if (accept) begin
                    s_result <= alu_res;
                    s_rd     <= in_rd;
                    s_we     <= new_we;
                end
            end else begin
                m_valid <= accept;
                if (accept) begin
                    m_result <= alu_res;
                    m_rd     <= in_rd;
                    m_we     <= new_we;
                end
            end
        end else if (accept) begin
            s_valid  <= 1'b1;
            s_result <= alu_res;
            s_rd     <= in_rd;
            s_we     <= new_we;
        end
    end

    assign out_valid  = m_valid;
    assign out_result = m_result;
    assign out_rd     = m_rd;
    assign out_we     = m_we;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: function sweep, backpressure ordering, x0 suppression, flush and async reset.
module tb_alu_exec_stage;

    localparam int RD_W = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_funct3;
    logic            in_funct7b5;
    logic            in_use_imm;
    logic [31:0]     in_rs1, in_rs2, in_imm;
    logic [RD_W-1:0] in_rd;
    logic            in_we;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_result;
    logic [RD_W-1:0] out_rd;
    logic            out_we;

    int vectors    = 0;
    int miscompares = 0;

    alu_exec_stage #(.RD_W(RD_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_funct3(in_funct3), .in_funct7b5(in_funct7b5), .in_use_imm(in_use_imm),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .in_rd(in_rd), .in_we(in_we),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rd(out_rd), .out_we(out_we)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  f3;
        logic        f7;
        logic        ui;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [31:0] exp;
    } vec_t;

    task automatic set_op(input logic [2:0] f3, input logic f7, input logic ui,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                          input logic [RD_W-1:0] rd, input logic we);
        in_funct3 = f3; in_funct7b5 = f7; in_use_imm = ui;
        in_rs1 = a; in_rs2 = b; in_imm = imm; in_rd = rd; in_we = we;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_result !== 32'h0 || out_we !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: out_valid=%b in_ready=%b out_result=%h out_we=%b, want 0 1 00000000 0",
                     out_valid, in_ready, out_result, out_we);
        end
    endtask

    task automatic test_functions();
        vec_t v[12];
        v[0]  = '{3'b000, 1'b0, 1'b0, 32'd7,          32'd5,          32'd0,  32'd12};
        v[1]  = '{3'b000, 1'b1, 1'b0, 32'h8000_0000, 32'd1,          32'd0,  32'h7FFF_FFFF};
        v[2]  = '{3'b000, 1'b1, 1'b1, 32'd3,          32'd100,        32'd1,  32'd4};
        v[3]  = '{3'b001, 1'b0, 1'b0, 32'd1,          32'd31,         32'd0,  32'h8000_0000};
        v[4]  = '{3'b100, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0,  32'h0FF0_0FF0};
        v[5]  = '{3'b110, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0,  32'hFFF0_FFF0};
        v[6]  = '{3'b111, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0,  32'hF000_F000};
        v[7]  = '{3'b101, 1'b1, 1'b0, 32'h8000_0000, 32'd36,         32'd0,  32'hF800_0000};
        v[8]  = '{3'b101, 1'b0, 1'b0, 32'h8000_0000, 32'd36,         32'd0,  32'h0800_0000};
        v[9]  = '{3'b010, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1,          32'd0,  32'd1};
        v[10] = '{3'b011, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1,          32'd0,  32'd0};
        v[11] = '{3'b001, 1'b0, 1'b1, 32'd3,          32'd0,          32'd4,  32'h30};
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            set_op(v[i].f3, v[i].f7, v[i].ui, v[i].rs1, v[i].rs2, v[i].imm, 5'd1, 1'b1);
            in_valid = 1'b1;
            step();
            vectors++;
            if (out_valid !== 1'b1 || out_result !== v[i].exp) begin
                miscompares++;
                $display("FAIL func_%0d: out_valid=%b out_result=%h, want 1 %h", i, out_valid, out_result, v[i].exp);
            end
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] got[$];
        int sent = 0;
        for (int c = 0; c < 10; c++) begin
            out_ready = (c >= 3);
            if (c == 2) begin
                vectors++;
                if (in_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL bp_full: in_ready=%b, want 0", in_ready);
                end
            end
            if (c == 1 || c == 2) begin
                vectors++;
                if (out_valid !== 1'b1 || out_result !== 32'd1) begin
                    miscompares++;
                    $display("FAIL bp_stall_%0d: out_valid=%b out_result=%h, want 1 00000001", c, out_valid, out_result);
                end
            end
            if (out_valid && out_ready) got.push_back(out_result);
            in_valid = (sent < 4);
            set_op(3'b000, 1'b0, 1'b0, 32'd0, 32'(sent + 1), 32'd0, 5'd2, 1'b1);
            if (in_valid && in_ready) begin
                step();
                sent++;
            end else begin
                step();
            end
        end
        in_valid = 1'b0;
        vectors++;
        if (got.size() != 4) begin
            miscompares++;
            $display("FAIL bp_count: received %0d results, want 4", got.size());
        end
        for (int i = 0; i < got.size() && i < 4; i++) begin
            vectors++;
            if (got[i] !== 32'(i + 1)) begin
                miscompares++;
                $display("FAIL bp_order_%0d: out_result=%h, want %h", i, got[i], 32'(i + 1));
            end
        end
    endtask

    task automatic test_x0();
        out_ready = 1'b1;
        set_op(3'b000, 1'b0, 1'b0, 32'd1, 32'd1, 32'd0, 5'd0, 1'b1);
        in_valid = 1'b1;
        step();
        vectors++;
        if (out_valid !== 1'b1 || out_we !== 1'b0) begin
            miscompares++;
            $display("FAIL x0_suppress: out_valid=%b out_we=%b, want 1 0", out_valid, out_we);
        end
        set_op(3'b000, 1'b0, 1'b0, 32'd1, 32'd1, 32'd0, 5'd5, 1'b1);
        step();
        vectors++;
        if (out_we !== 1'b1 || out_rd !== 5'd5) begin
            miscompares++;
            $display("FAIL x0_rd5: out_we=%b out_rd=%0d, want 1 5", out_we, out_rd);
        end
        set_op(3'b000, 1'b0, 1'b0, 32'd1, 32'd1, 32'd0, 5'd5, 1'b0);
        step();
        vectors++;
        if (out_we !== 1'b0) begin
            miscompares++;
            $display("FAIL x0_we0: out_we=%b, want 0", out_we);
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_flush();
        int seen = 0;
        out_ready = 1'b0;
        in_valid = 1'b1;
        set_op(3'b000, 1'b0, 1'b0, 32'h100, 32'd1, 32'd0, 5'd3, 1'b1);
        step();
        set_op(3'b000, 1'b0, 1'b0, 32'h100, 32'd2, 32'd0, 5'd3, 1'b1);
        step();
        set_op(3'b000, 1'b0, 1'b0, 32'h100, 32'd3, 32'd0, 5'd3, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_state: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (out_valid) seen++;
            step();
        end
        vectors++;
        if (seen != 0) begin
            miscompares++;
            $display("FAIL flush_leak: %0d results appeared, want 0", seen);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid = 1'b1;
        set_op(3'b000, 1'b0, 1'b0, 32'd9, 32'd9, 32'd0, 5'd4, 1'b1);
        step();
        step();
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_result !== 32'h0 || in_ready !== 1'b1 || out_rd !== '0) begin
            miscompares++;
            $display("FAIL async_reset: out_valid=%b out_result=%h in_ready=%b out_rd=%0d, want 0 00000000 1 0",
                     out_valid, out_result, in_ready, out_rd);
        end
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        set_op(3'b000, 1'b0, 1'b0, 32'd2, 32'd2, 32'd0, 5'd6, 1'b1);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || out_result !== 32'd4) begin
            miscompares++;
            $display("FAIL post_reset_op: out_valid=%b out_result=%h, want 1 00000004", out_valid, out_result);
        end
        step();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        set_op(3'b000, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        #12;
        test_reset();
        step();
        rst = 1'b0;
        step();
        test_functions();
        test_back_to_back();
        test_x0();
        test_flush();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
